// File: rtl/barrido_puntaje.sv
// BCD score counter (saturating 0000..9999) with a 4-digit multiplexed display scan.
// Optional macro BLANK_LEADING_ZEROS_EN turns off leading-zero digits 1..3.
module barrido_puntaje #(
    parameter int unsigned DIV_REFRESCO = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Acierto,
    input  logic        Fallo,
    output logic [15:0] Puntaje,
    output logic [3:0]  Digito,
    output logic [3:0]  Anodo
);

    logic [15:0] cuenta;
    logic [1:0]  indice;
    logic        tick;
    logic [15:0] siguiente;
    logic        acarreo;
    logic        prestamo;
    logic        apagar;

    assign tick = (cuenta == 16'(DIV_REFRESCO - 1));

    // Per-nibble ripple; saturation is decided on the whole BCD word before rippling.
    always_comb begin
        siguiente = Puntaje;
        acarreo   = 1'b1;
        prestamo  = 1'b1;
        if (Acierto && !Fallo && Puntaje != 16'h9999) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acarreo) begin
                    if (Puntaje[4*i +: 4] == 4'd9) begin
                        siguiente[4*i +: 4] = '0;
                    end else begin
                        siguiente[4*i +: 4] = Puntaje[4*i +: 4] + 4'd1;
                        acarreo = 1'b0;
                    end
                end
            end
        end else if (Fallo && !Acierto && Puntaje != 16'h0000) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (prestamo) begin
                    if (Puntaje[4*i +: 4] == 4'd0) begin
                        siguiente[4*i +: 4] = 4'd9;
                    end else begin
                        siguiente[4*i +: 4] = Puntaje[4*i +: 4] - 4'd1;
                        prestamo = 1'b0;
                    end
                end
            end
        end
    end

`ifdef BLANK_LEADING_ZEROS_EN
    always_comb begin
        apagar = 1'b0;
        case (indice)
            2'd1:    apagar = (Puntaje[15:4] == 12'h000);
            2'd2:    apagar = (Puntaje[15:8] == 8'h00);
            2'd3:    apagar = (Puntaje[15:12] == 4'h0);
            default: apagar = 1'b0;
        endcase
    end
`else
    assign apagar = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            Puntaje <= '0;
            cuenta  <= '0;
            indice  <= '0;
            Digito  <= '0;
            Anodo   <= '1;
        end else begin
            Puntaje <= siguiente;
            if (tick) begin
                cuenta <= '0;
                indice <= indice + 2'd1;
            end else begin
                cuenta <= cuenta + 16'd1;
            end
            // Anodo and Digito come from the same index sample so they always agree.
            Anodo  <= apagar ? 4'b1111 : ~(4'b0001 << indice);
            Digito <= Puntaje[4*indice +: 4];
        end
    end

endmodule
